// File: rtl/led_fader_if.sv
// Level-signal bundle between an LED-level source and led_fader.
// No handshake: i_led is a plain level sampled every cycle; all outputs are registered levels.
interface led_fader_if #(
  parameter int PWM_BITS = 8
);
  logic                i_led;
  logic                o_led;
  logic                o_busy;
  logic [PWM_BITS-1:0] o_level;
  logic [1:0]          dbg_state;

  modport master (output i_led, input o_led, o_busy, o_level, dbg_state);
  modport slave  (input i_led, output o_led, o_busy, o_level, dbg_state);
endinterface

// File: rtl/led_fader.sv
// PWM LED fader: ramps brightness linearly toward the synchronised i_led level.
// Optional gamma-corrected duty enabled by defining LED_FADER_GAMMA_EN.
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  led_fader_if.slave  bus
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [SW-1:0]       step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                s1_q, s1_d, s2_q, s2_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] level_inc, level_dec;

  assign level_inc = level_q + PWM_BITS'(1);
  assign level_dec = level_q - PWM_BITS'(1);

`ifdef LED_FADER_GAMMA_EN
  logic [PWM_BITS-1:0] duty_q, duty_d;

  always_comb begin
    duty_d = PWM_BITS'(((2*PWM_BITS)'(level_q) * (2*PWM_BITS)'(level_q)) >> PWM_BITS);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) duty_q <= '0;
    else         duty_q <= duty_d;
  end

  assign duty = duty_q;
`else
  assign duty = level_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_OFF;
      level_q <= '0;
      step_q  <= '0;
      pwm_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
      pwm_q   <= pwm_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  // Step counter idles at 0 outside ramps, so every state change restarts it.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = '0;
    unique case (state_q)
      S_OFF: begin
        level_d = '0;
        if (s2_q) state_d = S_UP;
      end
      S_UP: begin
        if (!s2_q) begin
          state_d = S_DOWN;
        end else if (step_q == STEP_LAST) begin
          level_d = level_inc;
          if (level_inc == MAX) state_d = S_ON;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      S_ON: begin
        level_d = MAX;
        if (!s2_q) state_d = S_DOWN;
      end
      S_DOWN: begin
        if (s2_q) begin
          state_d = S_UP;
        end else if (step_q == STEP_LAST) begin
          level_d = level_dec;
          if (level_dec == '0) state_d = S_OFF;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Full-on keys off the level itself so MAX stays solid even with gamma latency.
  always_comb begin
    s1_d   = bus.i_led;
    s2_d   = s1_q;
    pwm_d  = pwm_q + PWM_BITS'(1);
    busy_d = (state_d == S_UP) || (state_d == S_DOWN);
    led_d  = (level_q == MAX) ? 1'b1 : (pwm_q < duty);
  end

  assign bus.o_led     = led_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_level   = level_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader (PWM_BITS=4, STEP_DIV=2) with a level-step scoreboard.
module tb_led_fader;
  localparam int PB = 4;
  localparam int SD = 2;
  localparam int W  = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_fader_if #(.PWM_BITS(PB)) bus ();

  led_fader #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int cyc;
  int rise_t, fall_t;
  logic [PB-1:0] last_level;
  logic prev_busy;
  bit toggle_en;
  int highs;
  int exp_duty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples #1 after the edge, scoreboards level changes as {cycle, level}.
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.o_level !== last_level) begin
      if (exp_q.size() == 0) begin
        check("level_unexpected", 32'(bus.o_level), 32'(last_level));
      end else begin
        e = exp_q.pop_front();
        check("level_step", 32'({cyc[7:0], bus.o_level}), 32'(e));
      end
      last_level = bus.o_level;
    end
    if (bus.o_busy && !prev_busy && rise_t < 0) rise_t = cyc;
    if (!bus.o_busy && prev_busy && fall_t < 0) fall_t = cyc;
    prev_busy = bus.o_busy;
    if (toggle_en) bus.i_led = ~bus.i_led;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_test(input logic led);
    cyc       = 0;
    rise_t    = -1;
    fall_t    = -1;
    prev_busy = bus.o_busy;
    bus.i_led = led;
  endtask

  task automatic push_ramp(input int t0, input int l0, input int dir, input int n);
    logic [7:0] t;
    logic [3:0] l;
    for (int k = 1; k <= n; k++) begin
      t = 8'(t0 + SD * k);
      l = 4'(l0 + dir * k);
      exp_q.push_back({t, l});
    end
  endtask

  task automatic count_led(input int n, output int h);
    h = 0;
    repeat (n) begin
      tick();
      if (bus.o_led) h++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.i_led  = 1'b0;
    toggle_en  = 1'b0;
    last_level = '0;
    prev_busy  = 1'b0;
    cyc        = 0;
    rise_t     = -1;
    fall_t     = -1;
`ifdef LED_FADER_GAMMA_EN
    exp_duty = (5 * 5) >> PB;
`else
    exp_duty = 5;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset_led",   32'(bus.o_led),     32'd0);
    check("reset_busy",  32'(bus.o_busy),    32'd0);
    check("reset_level", 32'(bus.o_level),   32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    last_level = bus.o_level;
    run(3);

    // Ramp up 0 -> 15
    start_test(1'b1);
    push_ramp(3, 0, 1, 15);
    run(40);
    check("up_busy_rise", 32'(rise_t), 32'd3);
    check("up_busy_fall", 32'(fall_t), 32'd33);
    check("up_queue",     32'(exp_q.size()), 32'd0);
    check("up_state_on",  32'(bus.dbg_state), 32'd2);
    count_led(16, highs);
    check("up_led_full",  32'(highs), 32'd16);

    // Ramp down 15 -> 0
    start_test(1'b0);
    push_ramp(3, 15, -1, 15);
    run(40);
    check("down_busy_rise", 32'(rise_t), 32'd3);
    check("down_busy_fall", 32'(fall_t), 32'd33);
    check("down_queue",     32'(exp_q.size()), 32'd0);
    check("down_state_off", 32'(bus.dbg_state), 32'd0);
    count_led(16, highs);
    check("down_led_off",   32'(highs), 32'd0);
    check("down_busy_idle", 32'(bus.o_busy), 32'd0);

    // Reversal at level 7: DOWN takes over, level 6 two cycles later
    start_test(1'b1);
    push_ramp(3, 0, 1, 7);
    push_ramp(19, 7, -1, 7);
    run(16);
    bus.i_led = 1'b0;
    run(3);
    check("rev_state_down", 32'(bus.dbg_state), 32'd3);
    check("rev_level_hold", 32'(bus.o_level), 32'd7);
    run(22);
    check("rev_busy_rise", 32'(rise_t), 32'd3);
    check("rev_busy_fall", 32'(fall_t), 32'd33);
    check("rev_queue",     32'(exp_q.size()), 32'd0);
    check("rev_state_off", 32'(bus.dbg_state), 32'd0);

    // Freeze at level 5 by reversing every cycle, then measure duty
    start_test(1'b1);
    push_ramp(3, 0, 1, 5);
    run(12);
    bus.i_led = 1'b0;
    toggle_en = 1'b1;
    run(6);
    count_led(16, highs);
    check("pause_duty",  32'(highs), 32'(exp_duty));
    check("pause_level", 32'(bus.o_level), 32'd5);
    check("pause_busy",  32'(bus.o_busy), 32'd1);
    check("pause_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-cycle while ramping
    #3;
    rst = 1'b1;
    #1;
    check("areset_led",   32'(bus.o_led),     32'd0);
    check("areset_busy",  32'(bus.o_busy),    32'd0);
    check("areset_level", 32'(bus.o_level),   32'd0);
    check("areset_state", 32'(bus.dbg_state), 32'd0);
    toggle_en  = 1'b0;
    bus.i_led  = 1'b0;
    last_level = bus.o_level;
    prev_busy  = bus.o_busy;
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_led(16, highs);
    check("post_reset_led",   32'(highs), 32'd0);
    check("post_reset_level", 32'(bus.o_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
